eep_arbiter: RTL
================

# eep_arbiter

Sequences and shares the single EEPROM port between two requesters: the PID loop, which reads the Xset, P, I and D coefficients, and the command interpreter, which issues host read and write commands. The block owns every EEPROM control pin and the charge-pump enable. It times the write charge-pump window and alternates grants so neither requester is starved. It sits between the control FSM and the EEPROM macro.

## Interface
Parameters:
- CHRG_CYCLES, default 2400000: number of cycles the charge pump is held for a write (3 ms at the system clock).
- CNT_W, default 22: width of the charge counter. Must satisfy 2^CNT_W > CHRG_CYCLES.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- pid_req  in  1  PID read request. Held high until pid_gnt.
- pid_addr  in  2  PID read address.
- pid_gnt  out  1  one-cycle pulse: the PID request has been accepted.
- pid_vld  out  1  one-cycle pulse: pid_rdata is valid.
- pid_rdata  out  14  PID read data.
- cmd_req  in  1  command request. Held high until cmd_gnt.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  2  command address.
- cmd_wdata  in  14  command write data.
- cmd_gnt  out  1  one-cycle pulse: the command request has been accepted.
- cmd_done  out  1  one-cycle pulse: the command is complete.
- cmd_rdata  out  14  read data, or read-back data after a verified write.
- cmd_err  out  1  write verify mismatch; valid with cmd_done.
- eep_addr  out  2  EEPROM address.
- eep_cs_n  out  1  EEPROM chip select, active-low.
- eep_r_w_n  out  1  1 = read, 0 = write.
- eep_wdata  out  14  EEPROM write data.
- eep_rdata  in  14  EEPROM read data. Combinational: valid in the same cycle eep_cs_n=0 and eep_r_w_n=1.
- chrg_pmp_en  out  1  charge-pump enable.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE
  - RD: one cycle; EEPROM selected for read.
  - WR_CHRG: write in progress with the charge pump on.
  - WR_VFY: exists only with the macro defined; one-cycle read-back.
  - DONE: one cycle; completion pulse.
- Arbitration in IDLE:
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - The `last` flag resets to cmd, so PID wins the first tie.
- Grant:
  - On the IDLE→RD/WR_CHRG edge, the winner's address and write data are latched into the eep_addr/eep_wdata registers and a direction flag is latched.
  - The gnt pulse is asserted during the first cycle of RD or WR_CHRG.
- PID requests are always reads. The PID path ignores cmd_we.
- RD: eep_cs_n=0, eep_r_w_n=1. eep_rdata is captured into the owner's rdata register at the end of the cycle. Next state is DONE.
- WR_CHRG:
  - Outputs: eep_cs_n=0, eep_r_w_n=0, chrg_pmp_en=1.
  - The counter clears on entry and increments each cycle.
  - When the counter reaches CHRG_CYCLES-1, the block leaves for WR_VFY (macro defined) or DONE (macro undefined). The state therefore lasts exactly CHRG_CYCLES cycles.
- DONE:
  - All EEPROM pins return to idle values.
  - pid_vld pulses if the owner was PID; cmd_done pulses if the owner was cmd.
  - Next state is IDLE.
- Requests are not sampled while busy. New requests may be granted starting in the cycle after DONE.
- Reset values: state=IDLE; counter=0; eep_cs_n=1; eep_r_w_n=1; chrg_pmp_en=0; eep_addr=0; eep_wdata=0; all pulse outputs 0; pid_rdata=0; cmd_rdata=0; cmd_err=0; busy=0; last=cmd.
- Reset during a write: at the next edge with rst_n=0, chrg_pmp_en drops and the block returns to IDLE. No cmd_done is issued and the write is abandoned.
- A request that drops before its grant is simply not served. A request held high through DONE is re-arbitrated as a new access.

## Timing
- Read: req sampled high in IDLE at edge N.
  - Cycle N+1: RD, gnt=1, eep_cs_n=0.
  - Cycle N+2: DONE, vld/done=1, data valid.
  - Read data stays stable until the next read by the same owner.
- Write: gnt in cycle N+1, then WR_CHRG for CHRG_CYCLES cycles.
  - Macro undefined: DONE in cycle N+1+CHRG_CYCLES.
  - Macro defined: one more cycle (WR_VFY), so DONE is one cycle later.
- Back-to-back: the minimum spacing between consecutive grants is 3 cycles (RD, DONE, IDLE).
- chrg_pmp_en is never high outside WR_CHRG.
- eep_r_w_n=0 only occurs while chrg_pmp_en=1.

## Configuration
- EEP_ARB_WR_VERIFY_EN defined:
  - After WR_CHRG, the WR_VFY state drives eep_cs_n=0, eep_r_w_n=1 for one cycle.
  - The read-back value is latched into cmd_rdata.
  - cmd_err = (read-back != latched wdata), updated with cmd_done and held until the next command's done.
- EEP_ARB_WR_VERIFY_EN undefined:
  - WR_VFY does not exist.
  - cmd_err is tied to 0.
  - cmd_rdata is unchanged by writes.

## Test plan
All scenarios use CHRG_CYCLES=8.
- PID read: pid_req, pid_addr=2'b01, EEPROM model returns 14'h0123 → pid_gnt 1 cycle after sampling, pid_vld 2 cycles after sampling, pid_rdata=14'h0123, cmd outputs quiet.
- Command write: cmd_we=1, cmd_addr=2'b11, cmd_wdata=14'h1A5A → chrg_pmp_en and eep_r_w_n=0 for exactly 8 cycles with eep_addr=3, eep_wdata=14'h1A5A; cmd_done follows; with the macro defined and a correct model, cmd_err=0 and cmd_rdata=14'h1A5A.
- Verify fail (macro defined): the model corrupts the write to 14'h1A5B → cmd_done with cmd_err=1 and cmd_rdata=14'h1A5B.
- Tie: pid_req and cmd_req both held high from reset → PID granted first, then cmd, then PID again, alternating with no requester served twice in a row.
- Write stalls PID: pid_req rises during cycle 3 of WR_CHRG → no pid_gnt until 2 cycles after the write's DONE, because IDLE samples it at the first edge after DONE.
- Reset mid-write: rst_n=0 in cycle 4 of WR_CHRG → at the next edge chrg_pmp_en=0, eep_cs_n=1, busy=0; no cmd_done.

Source files
------------

// File: rtl/eep_arbiter.sv
// EEPROM port arbiter: shares one EEPROM between the PID coefficient reader and the
// host command interpreter, timing the write charge pump. Optional macro: EEP_ARB_WR_VERIFY_EN.
module eep_arbiter #(
    parameter int unsigned CHRG_CYCLES = 2400000,
    parameter int unsigned CNT_W       = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pid_req,
    input  logic [1:0]  pid_addr,
    output logic        pid_gnt,
    output logic        pid_vld,
    output logic [13:0] pid_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_addr,
    input  logic [13:0] cmd_wdata,
    output logic        cmd_gnt,
    output logic        cmd_done,
    output logic [13:0] cmd_rdata,
    output logic        cmd_err,
    output logic [1:0]  eep_addr,
    output logic        eep_cs_n,
    output logic        eep_r_w_n,
    output logic [13:0] eep_wdata,
    input  logic [13:0] eep_rdata,
    output logic        chrg_pmp_en,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_WR_CHRG = 3'd2;
`ifdef EEP_ARB_WR_VERIFY_EN
    localparam logic [2:0] S_WR_VFY  = 3'd3;
`endif
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHRG_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;   // 1 = command interpreter owns the access
    logic             last_q, last_d;     // 1 = command was granted last
    logic             we_q, we_d;
    logic             pick_cmd;
    logic [1:0]       eep_addr_q, eep_addr_d;
    logic [13:0]      eep_wdata_q, eep_wdata_d;
    logic [13:0]      pid_rdata_q, pid_rdata_d;
    logic [13:0]      cmd_rdata_q, cmd_rdata_d;
    logic             eep_cs_n_q, eep_cs_n_d;
    logic             eep_r_w_n_q, eep_r_w_n_d;
    logic             chrg_pmp_en_q, chrg_pmp_en_d;
    logic             busy_q, busy_d;
    logic             pid_gnt_q, pid_gnt_d;
    logic             cmd_gnt_q, cmd_gnt_d;
    logic             pid_vld_q, pid_vld_d;
    logic             cmd_done_q, cmd_done_d;
`ifdef EEP_ARB_WR_VERIFY_EN
    logic             cmd_err_q, cmd_err_d;
`endif

    // Next state, datapath capture, and registered outputs derived from the next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        pick_cmd    = 1'b0;
        eep_addr_d  = eep_addr_q;
        eep_wdata_d = eep_wdata_q;
        pid_rdata_d = pid_rdata_q;
        cmd_rdata_d = cmd_rdata_q;
`ifdef EEP_ARB_WR_VERIFY_EN
        cmd_err_d   = cmd_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pid_req || cmd_req) begin
                    pick_cmd   = cmd_req && (!pid_req || !last_q);
                    owner_d    = pick_cmd;
                    last_d     = pick_cmd;
                    we_d       = pick_cmd && cmd_we;
                    eep_addr_d = pick_cmd ? cmd_addr : pid_addr;
                    if (pick_cmd) begin
                        eep_wdata_d = cmd_wdata;
                    end
                    cnt_d   = '0;
                    state_d = we_d ? S_WR_CHRG : S_RD;
                end
            end
            S_RD: begin
                if (owner_q) begin
                    cmd_rdata_d = eep_rdata;
`ifdef EEP_ARB_WR_VERIFY_EN
                    cmd_err_d   = 1'b0;
`endif
                end else begin
                    pid_rdata_d = eep_rdata;
                end
                state_d = S_DONE;
            end
            S_WR_CHRG: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef EEP_ARB_WR_VERIFY_EN
                    state_d = S_WR_VFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef EEP_ARB_WR_VERIFY_EN
            S_WR_VFY: begin
                cmd_rdata_d = eep_rdata;
                cmd_err_d   = (eep_rdata != eep_wdata_q);
                state_d     = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        eep_cs_n_d    = (state_d == S_IDLE) || (state_d == S_DONE);
        eep_r_w_n_d   = (state_d != S_WR_CHRG);
        chrg_pmp_en_d = (state_d == S_WR_CHRG);
        busy_d        = (state_d != S_IDLE);
        pid_gnt_d     = (state_q == S_IDLE) && (state_d != S_IDLE) && !owner_d;
        cmd_gnt_d     = (state_q == S_IDLE) && (state_d != S_IDLE) && owner_d;
        pid_vld_d     = (state_d == S_DONE) && !owner_d;
        cmd_done_d    = (state_d == S_DONE) && owner_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            we_q          <= 1'b0;
            eep_addr_q    <= '0;
            eep_wdata_q   <= '0;
            pid_rdata_q   <= '0;
            cmd_rdata_q   <= '0;
            eep_cs_n_q    <= 1'b1;
            eep_r_w_n_q   <= 1'b1;
            chrg_pmp_en_q <= 1'b0;
            busy_q        <= 1'b0;
            pid_gnt_q     <= 1'b0;
            cmd_gnt_q     <= 1'b0;
            pid_vld_q     <= 1'b0;
            cmd_done_q    <= 1'b0;
`ifdef EEP_ARB_WR_VERIFY_EN
            cmd_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            we_q          <= we_d;
            eep_addr_q    <= eep_addr_d;
            eep_wdata_q   <= eep_wdata_d;
            pid_rdata_q   <= pid_rdata_d;
            cmd_rdata_q   <= cmd_rdata_d;
            eep_cs_n_q    <= eep_cs_n_d;
            eep_r_w_n_q   <= eep_r_w_n_d;
            chrg_pmp_en_q <= chrg_pmp_en_d;
            busy_q        <= busy_d;
            pid_gnt_q     <= pid_gnt_d;
            cmd_gnt_q     <= cmd_gnt_d;
            pid_vld_q     <= pid_vld_d;
            cmd_done_q    <= cmd_done_d;
`ifdef EEP_ARB_WR_VERIFY_EN
            cmd_err_q     <= cmd_err_d;
`endif
        end
    end

    assign pid_gnt     = pid_gnt_q;
    assign pid_vld     = pid_vld_q;
    assign pid_rdata   = pid_rdata_q;
    assign cmd_gnt     = cmd_gnt_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_rdata   = cmd_rdata_q;
    assign eep_addr    = eep_addr_q;
    assign eep_cs_n    = eep_cs_n_q;
    assign eep_r_w_n   = eep_r_w_n_q;
    assign eep_wdata   = eep_wdata_q;
    assign chrg_pmp_en = chrg_pmp_en_q;
    assign busy        = busy_q;
`ifdef EEP_ARB_WR_VERIFY_EN
    assign cmd_err     = cmd_err_q;
`else
    assign cmd_err     = 1'b0;
`endif

endmodule
